clk_ctrl: RTL and testbench

CLK_CTRL -- requirements
Module: clk_ctrl

---
 rtl/clk_ctrl_pkg.sv | 51 +++++
 rtl/clk_ctrl_sync2.sv | 33 +++
 rtl/clk_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_clk_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock controller: register map, field positions, FSM encoding.
// Latency: n/a (constants, types and pure helper functions only).
// Backpressure: n/a.
package clk_ctrl_pkg;

   // Register indices on the 2-bit bus address
   localparam logic [1:0] ADDR_CLKSEL = 2'd0;
   localparam logic [1:0] ADDR_LDIV   = 2'd1;
   localparam logic [1:0] ADDR_STATUS = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   // CLKSEL fields
   localparam int CLKSEL_XTNL_BIT = 2;

   // LDIV fields
   localparam int LDIV_EN_BIT = 7;

   // STATUS fields
   localparam int STATUS_TERR_BIT = 2;

   // Clock-select encodings
   localparam logic [1:0] SEL_REF   = 2'b00;
   localparam logic [1:0] SEL_SLEEP = 2'b11;

   // Divider enable is held low this many cycles before a new ratio is loaded
   localparam int unsigned LDIV_OFF_CYCLES = 2;
   localparam logic [5:0]  LDIV_RATIO_MIN  = 6'd2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_LDIV_OFF  = 3'd3,
      ST_SLEEP     = 3'd4
   } state_t;

   // Selections 01/10 run from the PLL and therefore depend on lock
   function automatic logic is_pll_sel(input logic [1:0] sel);
      return (sel == 2'b01) || (sel == 2'b10);
   endfunction

   // Ratios below 2 are not supported by the divider
   function automatic logic [5:0] clamp_ratio(input logic [5:0] ratio);
      return (ratio < LDIV_RATIO_MIN) ? LDIV_RATIO_MIN : ratio;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/clk_ctrl_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the CLK domain.
// Latency: 2 CLK cycles from a stable input to the output.
// Backpressure: none; free-running.
module sync2 (
   input  logic CLK,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Next-state for the two synchronizer stages
   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
   end

   // Synchronizer flops, cleared by reset
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/clk_ctrl.sv
// Clock controller: register block plus sequencer for core clock mux, PLL ref select and divider.
// Latency: reads and non-blocked writes complete in the access cycle; outputs change the cycle after.
// Backpressure: CLKSEL/LDIV writes hold bus_ready low while the sequencer is busy.
module clk_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int unsigned LOCK_TIMEOUT   = 1023,
   parameter int unsigned SETTLE_CYCLES  = 8,
   parameter logic [1:0]  RESET_CCLK_SEL = 2'b00
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic       bus_sel,
   input  logic       bus_we,
   input  logic [1:0] bus_addr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] bus_rdata,
   output logic       bus_ready,
   input  logic       pll_lock,
   input  logic       wake,
   output logic [1:0] cclk_sel,
   output logic       xtnlclk_sel,
   output logic       LDIV_ENABLE,
   output logic [5:0] LDIV_RATIO,
   output logic       busy,
   output logic       irq
);

   localparam int unsigned CNT_W = $clog2(max_u(LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;
   localparam logic [CNT_W-1:0] CNT_TIMEOUT     = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_LDIV_LAST   = CNT_W'(LDIV_OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX         = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]       cclk_sel_q, cclk_sel_d;
   logic [1:0]       req_q, req_d;
   logic [1:0]       prev_q, prev_d;
   logic             xtnl_q, xtnl_d;
   logic             ldiv_en_q, ldiv_en_d;
   logic [5:0]       ldiv_ratio_q, ldiv_ratio_d;
   logic             pend_en_q, pend_en_d;
   logic [5:0]       pend_ratio_q, pend_ratio_d;
   logic             terr_q, terr_d;

   logic             lock_s;
   logic             wr, wr_cfg, lock_loss;
   logic [1:0]       wreq;
   logic             wdata_unused;

   sync2 u_sync2 (
      .CLK     (CLK),
      .rst     (rst),
      .async_i (pll_lock),
      .sync_o  (lock_s)
   );

   assign wr           = bus_sel & bus_we;
   assign wr_cfg       = wr & ((bus_addr == ADDR_CLKSEL) | (bus_addr == ADDR_LDIV));
   assign wreq         = bus_wdata[1:0];
   assign lock_loss    = (state_q == ST_IDLE) & is_pll_sel(cclk_sel_q) & ~lock_s;
   assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign wdata_unused = bus_wdata[6];

   // Sequencer next-state, register updates and bus handshake
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cclk_sel_d   = cclk_sel_q;
      req_d        = req_q;
      prev_d       = prev_q;
      xtnl_d       = xtnl_q;
      ldiv_en_d    = ldiv_en_q;
      ldiv_ratio_d = ldiv_ratio_q;
      pend_en_d    = pend_en_q;
      pend_ratio_d = pend_ratio_q;
      terr_d       = terr_q;
      // A lock-loss cycle also stalls config writes so they are not silently dropped
      bus_ready    = ~(wr_cfg & ((state_q != ST_IDLE) | lock_loss));

      // Clear first so a same-cycle timeout/lock-loss set takes priority
      if (wr && bus_addr == ADDR_STATUS && bus_wdata[STATUS_TERR_BIT]) begin
         terr_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (lock_loss) begin
               cclk_sel_d = SEL_REF;
               terr_d     = 1'b1;
               cnt_d      = '0;
               state_d    = ST_SETTLE;
            end else if (wr && bus_addr == ADDR_CLKSEL) begin
               req_d = wreq;
               cnt_d = '0;
               if (cclk_sel_q == SEL_REF || wreq == SEL_REF) begin
                  xtnl_d = bus_wdata[CLKSEL_XTNL_BIT];
               end
               if (wreq == SEL_REF) begin
                  cclk_sel_d = SEL_REF;
                  state_d    = ST_SETTLE;
               end else if (wreq == SEL_SLEEP) begin
                  prev_d     = cclk_sel_q;
                  cclk_sel_d = SEL_SLEEP;
                  state_d    = ST_SLEEP;
               end else if (lock_s) begin
                  cclk_sel_d = wreq;
                  state_d    = ST_SETTLE;
               end else begin
                  state_d = ST_WAIT_LOCK;
               end
            end else if (wr && bus_addr == ADDR_LDIV) begin
               pend_en_d    = bus_wdata[LDIV_EN_BIT];
               pend_ratio_d = bus_wdata[5:0];
               ldiv_en_d    = 1'b0;
               cnt_d        = '0;
               state_d      = ST_LDIV_OFF;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               cclk_sel_d = req_q;
               cnt_d      = '0;
               state_d    = ST_SETTLE;
            end else if (cnt_q == CNT_TIMEOUT) begin
               terr_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_SETTLE: begin
            if (cnt_q >= CNT_SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_LDIV_OFF: begin
            if (cnt_q >= CNT_LDIV_LAST) begin
               ldiv_en_d    = pend_en_q;
               ldiv_ratio_d = clamp_ratio(pend_ratio_q);
               cnt_d        = '0;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_SLEEP: begin
            if (wake) begin
               // Never wake onto an unlocked PLL
               cclk_sel_d = (is_pll_sel(prev_q) && !lock_s) ? SEL_REF : prev_q;
               cnt_d      = '0;
               state_d    = ST_SETTLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and register flops; reset abandons any sequence in progress
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cclk_sel_q   <= RESET_CCLK_SEL;
         req_q        <= RESET_CCLK_SEL;
         prev_q       <= SEL_REF;
         xtnl_q       <= 1'b0;
         ldiv_en_q    <= 1'b0;
         ldiv_ratio_q <= LDIV_RATIO_MIN;
         pend_en_q    <= 1'b0;
         pend_ratio_q <= LDIV_RATIO_MIN;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cclk_sel_q   <= cclk_sel_d;
         req_q        <= req_d;
         prev_q       <= prev_d;
         xtnl_q       <= xtnl_d;
         ldiv_en_q    <= ldiv_en_d;
         ldiv_ratio_q <= ldiv_ratio_d;
         pend_en_q    <= pend_en_d;
         pend_ratio_q <= pend_ratio_d;
         terr_q       <= terr_d;
      end
   end

   // Read mux straight from current register state
   always_comb begin
      bus_rdata = 8'h00;
      case (bus_addr)
         ADDR_CLKSEL: bus_rdata = {5'b0, xtnl_q, req_q};
         ADDR_LDIV:   bus_rdata = {ldiv_en_q, 1'b0, ldiv_ratio_q};
         ADDR_STATUS: bus_rdata = {3'b0, cclk_sel_q, terr_q, busy, lock_s};
         ADDR_RSVD:   bus_rdata = 8'h00;
         default:     bus_rdata = 8'h00;
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign irq         = terr_q;
   assign cclk_sel    = cclk_sel_q;
   assign xtnlclk_sel = xtnl_q;
   assign LDIV_ENABLE = ldiv_en_q;
   assign LDIV_RATIO  = ldiv_ratio_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// Self-checking bench for clk_ctrl: directed scenarios then random register traffic.
// Latency: n/a.
// Backpressure: bus writes wait on bus_ready with a bounded stall budget.
module tb_clk_ctrl;

   localparam int LT = 15;
   localparam int SC = 8;

   logic       CLK = 1'b0;
   logic       rst = 1'b1;
   logic       bus_sel = 1'b0, bus_we = 1'b0;
   logic [1:0] bus_addr = 2'd0;
   logic [7:0] bus_wdata = 8'h00;
   logic [7:0] bus_rdata;
   logic       bus_ready;
   logic       pll_lock = 1'b0, wake = 1'b0;
   logic [1:0] cclk_sel;
   logic       xtnlclk_sel, LDIV_ENABLE, busy, irq;
   logic [5:0] LDIV_RATIO;

   int n_chk = 0;
   int n_err = 0;

   // Transaction-level reference state
   logic [1:0] m_sel, m_req, m_prev;
   logic       m_xtnl, m_en, m_terr, m_sleep;
   logic [5:0] m_ratio;

   always #5 CLK = ~CLK;

   clk_ctrl #(.LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .RESET_CCLK_SEL(2'b00)) dut (
      .CLK(CLK), .rst(rst), .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .pll_lock(pll_lock), .wake(wake), .cclk_sel(cclk_sel), .xtnlclk_sel(xtnlclk_sel),
      .LDIV_ENABLE(LDIV_ENABLE), .LDIV_RATIO(LDIV_RATIO), .busy(busy), .irq(irq)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic is_pll(input logic [1:0] s);
      return (s == 2'b01) || (s == 2'b10);
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      m_sel = 2'b00; m_req = 2'b00; m_prev = 2'b00; m_xtnl = 1'b0;
      m_en = 1'b0; m_ratio = 6'd2; m_terr = 1'b0; m_sleep = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d, output int stalls);
      stalls = 0;
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      #1;
      while (!bus_ready && stalls < 200) begin
         tick();
         stalls++;
      end
      chk("wr_ready_bound", 32'(bus_ready), 32'd1);
      @(posedge CLK);
      #1;
      bus_sel = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a;
      #1;
      chk("rd_ready", 32'(bus_ready), 32'd1);
      d = bus_rdata;
      bus_sel = 1'b0;
      tick();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      chk("idle_bound", 32'(busy), 32'd0);
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_sel"},   32'(cclk_sel),    32'(m_sel));
      chk({tag, "_xtnl"},  32'(xtnlclk_sel), 32'(m_xtnl));
      chk({tag, "_en"},    32'(LDIV_ENABLE), 32'(m_en));
      chk({tag, "_ratio"}, 32'(LDIV_RATIO),  32'(m_ratio));
      chk({tag, "_irq"},   32'(irq),         32'(m_terr));
   endtask

   task automatic check_regs();
      logic [7:0] d;
      bus_read(2'd0, d); chk("rd_clksel", 32'(d), 32'({5'b0, m_xtnl, m_req}));
      bus_read(2'd1, d); chk("rd_ldiv",   32'(d), 32'({m_en, 1'b0, m_ratio}));
      bus_read(2'd2, d); chk("rd_status", 32'(d), 32'({3'b0, m_sel, m_terr, m_sleep, pll_lock}));
      bus_read(2'd3, d); chk("rd_rsvd",   32'(d), 32'd0);
   endtask

   task automatic do_clksel(input logic [7:0] v);
      int st, n, exp_n;
      logic [1:0] r;
      logic will_timeout;
      r = v[1:0];
      will_timeout = 1'b0;
      exp_n = SC;
      bus_write(2'd0, v, st);
      chk("clksel_stall", 32'(st), 32'd0);
      if (m_sel == 2'b00 || r == 2'b00) m_xtnl = v[2];
      m_req = r;
      if (r == 2'b00) begin
         m_sel = 2'b00;
      end else if (r == 2'b11) begin
         m_prev = m_sel; m_sel = 2'b11; m_sleep = 1'b1;
      end else if (pll_lock) begin
         m_sel = r;
      end else begin
         will_timeout = 1'b1;
         exp_n = LT + 1;
      end
      chk("clksel_next_sel", 32'(cclk_sel), 32'(m_sel));
      chk("clksel_busy", 32'(busy), 32'd1);
      if (m_sleep) begin
         tick(); tick();
         chk("sleep_busy", 32'(busy), 32'd1);
      end else begin
         wait_idle(n);
         chk("clksel_busy_cycles", 32'(n), 32'(exp_n));
         if (will_timeout) m_terr = 1'b1;
      end
      check_outputs("clksel");
   endtask

   task automatic do_ldiv(input logic [7:0] v, input int exp_stall);
      int st, n;
      bus_write(2'd1, v, st);
      chk("ldiv_stall", 32'(st), 32'(exp_stall));
      chk("ldiv_off1", 32'(LDIV_ENABLE), 32'd0);
      tick();
      chk("ldiv_off2", 32'(LDIV_ENABLE), 32'd0);
      wait_idle(n);
      chk("ldiv_busy_cycles", 32'(n), 32'd1);
      m_en = v[7];
      m_ratio = (v[5:0] < 6'd2) ? 6'd2 : v[5:0];
      check_outputs("ldiv");
   endtask

   task automatic do_wake();
      int n;
      wake = 1'b1;
      tick();
      wake = 1'b0;
      m_sel = (is_pll(m_prev) && !pll_lock) ? 2'b00 : m_prev;
      m_sleep = 1'b0;
      chk("wake_sel", 32'(cclk_sel), 32'(m_sel));
      wait_idle(n);
      chk("wake_busy_cycles", 32'(n), 32'(SC));
      check_outputs("wake");
   endtask

   task automatic do_lock(input logic v);
      int n;
      logic loss;
      pll_lock = v;
      tick(); tick(); tick();
      loss = !m_sleep && is_pll(m_sel) && !v;
      chk("lock_busy", 32'(busy), 32'(loss | m_sleep));
      if (loss) begin
         m_sel = 2'b00;
         m_terr = 1'b1;
      end
      if (!m_sleep) wait_idle(n);
      check_outputs("lock");
   endtask

   task automatic do_status(input logic [7:0] v);
      int st;
      bus_write(2'd2, v, st);
      chk("status_stall", 32'(st), 32'd0);
      if (v[2]) m_terr = 1'b0;
      check_outputs("status");
      check_regs();
   endtask

   initial begin
      int st;
      model_reset();
      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(bus_ready), 32'd1);
      check_outputs("rst");
      rst = 1'b0;
      tick();
      check_regs();

      // Switch to PLL with lock present
      do_lock(1'b1);
      do_clksel(8'h02);
      // Back to reference, drop lock, then time out waiting for lock
      do_clksel(8'h00);
      do_lock(1'b0);
      do_clksel(8'h01);
      do_status(8'h04);
      // Divider reload with ratio clamp
      do_ldiv(8'h81, 0);
      // Sleep and wake, with and without lock
      do_lock(1'b1);
      do_clksel(8'h02);
      do_clksel(8'h03);
      do_wake();
      do_clksel(8'h03);
      do_lock(1'b0);
      do_wake();
      // Divider write issued during SETTLE stalls until IDLE
      bus_write(2'd0, 8'h00, st);
      m_sel = 2'b00; m_req = 2'b00; m_xtnl = 1'b0;
      do_ldiv(8'h85, SC);
      // Reset in the middle of a lock wait
      bus_write(2'd0, 8'h01, st);
      tick(); tick(); tick();
      chk("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(bus_ready), 32'd1);
      check_outputs("midrst");
      tick();
      rst = 1'b0;
      tick();

      // Random register traffic against the model
      for (int i = 0; i < 60; i++) begin
         int op;
         if (m_sleep) begin
            op = $urandom_range(0, 2);
            case (op)
               0: do_wake();
               1: do_lock(1'($urandom));
               default: do_status(8'($urandom));
            endcase
         end else begin
            op = $urandom_range(0, 5);
            case (op)
               0, 1: do_clksel(8'($urandom));
               2: do_ldiv(8'($urandom), 0);
               3: do_lock(1'($urandom));
               4: do_status(8'($urandom));
               default: check_regs();
            endcase
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

endmodule
